// File: rtl/demux_1to2_buf_if.sv
// -----------------------------------------------------------------------------
// demux_1to2_buf_if
// Handshake bundle for the buffered 1-to-2 demultiplexer.
//
// Ports (signals carried by the interface):
//   InData     [WIDTH]  word to route
//   Selector   [1]      0 -> channel A, 1 -> channel B
//   InValid    [1]      InData/Selector are valid
//   InReady    [1]      demux accepts a word this cycle
//   OutA/OutB  [WIDTH]  head-of-FIFO data per channel
//   OutX_Valid [1]      channel FIFO non-empty
//   OutX_Ready [1]      consumer takes the head word
//   CountA/B   [16]     accepted-word statistics
//
// Modports:
//   master - the environment (producer + both consumers)
//   slave  - the demux itself
// -----------------------------------------------------------------------------
interface demux_1to2_buf_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] InData;
  logic             Selector;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             OutA_Valid;
  logic             OutB_Valid;
  logic             OutA_Ready;
  logic             OutB_Ready;
  logic [15:0]      CountA;
  logic [15:0]      CountB;

  modport master (
    output InData, Selector, InValid, OutA_Ready, OutB_Ready,
    input  InReady, OutA, OutB, OutA_Valid, OutB_Valid, CountA, CountB
  );

  modport slave (
    input  InData, Selector, InValid, OutA_Ready, OutB_Ready,
    output InReady, OutA, OutB, OutA_Valid, OutB_Valid, CountA, CountB
  );
endinterface

// File: rtl/demux_1to2_buf.sv
// -----------------------------------------------------------------------------
// demux_1to2_buf
// Buffered 1-to-2 demultiplexer. One valid/ready producer stream is split into
// two channels, each with its own DEPTH-entry FIFO, so a stalled consumer on
// one channel never blocks or reorders the other.
//
// Parameters:
//   WIDTH  data width (default 32)
//   DEPTH  entries per channel FIFO, power of two >= 2 (default 2)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  demux_1to2_buf_if.slave (input handshake, two output channels, stats)
//
// Optional feature macro: DEMUX_STATS_EN
//   defined     -> CountA/CountB count accepted words per channel, saturating
//                  at 16'hFFFF, cleared by reset
//   not defined -> CountA/CountB are tied to zero
// -----------------------------------------------------------------------------
module demux_1to2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  demux_1to2_buf_if.slave bus
);

  localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  // Channel index 0 = A, 1 = B throughout.
  logic [WIDTH-1:0] r_mem    [2][DEPTH];
  logic [PW-1:0]    r_rd_ptr [2];
  logic [PW-1:0]    r_wr_ptr [2];
  logic [CW-1:0]    r_occ    [2];
  logic [WIDTH-1:0] r_head   [2];

  logic             w_in_ready;
  logic             w_out_ready [2];
  logic             w_push      [2];
  logic             w_pop       [2];
  logic [PW-1:0]    w_rd_next   [2];

  // NOTE: every signal written here is assigned on every pass, so no latches.
  always_comb begin
    w_out_ready[0] = bus.OutA_Ready;
    w_out_ready[1] = bus.OutB_Ready;
    // Depends only on Selector and registered occupancy, never on InValid.
    w_in_ready = !rst && (r_occ[bus.Selector] < FULL);
    for (int c = 0; c < 2; c++) begin
      w_push[c]    = bus.InValid && w_in_ready && (int'(bus.Selector) == c);
      w_pop[c]     = (r_occ[c] != '0) && w_out_ready[c];
      w_rd_next[c] = r_rd_ptr[c] + 1'b1;
    end
  end

  // NOTE: the storage array carries no reset; occupancy alone says which
  // entries are live, so a reset of the array would only cost flops.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wr_ptr[c]] <= bus.InData;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_occ[c]    <= '0;
        r_head[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        end
        if (w_pop[c]) begin
          r_rd_ptr[c] <= w_rd_next[c];
        end

        if (w_push[c] && !w_pop[c]) begin
          r_occ[c] <= r_occ[c] + 1'b1;
        end else if (!w_push[c] && w_pop[c]) begin
          r_occ[c] <= r_occ[c] - 1'b1;
        end

        // Registered head: tracks the entry at the read pointer after this
        // edge and simply holds its value once the channel drains.
        if (w_pop[c]) begin
          if (r_occ[c] == CW'(1)) begin
            // Only entry leaves; a same-cycle push becomes the new head
            // before it is visible in the array.
            if (w_push[c]) begin
              r_head[c] <= bus.InData;
            end
          end else begin
            r_head[c] <= r_mem[c][w_rd_next[c]];
          end
        end else if ((r_occ[c] == '0) && w_push[c]) begin
          r_head[c] <= bus.InData;
        end
      end
    end
  end

  assign bus.InReady    = w_in_ready;
  assign bus.OutA       = r_head[0];
  assign bus.OutB       = r_head[1];
  assign bus.OutA_Valid = (r_occ[0] != '0);
  assign bus.OutB_Valid = (r_occ[1] != '0);

`ifdef DEMUX_STATS_EN
  logic [15:0] r_count [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count[0] <= '0;
      r_count[1] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c] && (r_count[c] != 16'hFFFF)) begin
          r_count[c] <= r_count[c] + 16'd1;
        end
      end
    end
  end

  assign bus.CountA = r_count[0];
  assign bus.CountB = r_count[1];
`else
  assign bus.CountA = '0;
  assign bus.CountB = '0;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2_buf
// Self-checking bench for demux_1to2_buf. A queue-based reference model tracks
// each channel's contents; a compare process checks every output on every
// falling edge, and directed sequences pin known literal values.
// -----------------------------------------------------------------------------
module tb_demux_1to2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  demux_1to2_buf_if #(.WIDTH(WIDTH)) bus ();

  demux_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one queue per channel, the value last shown on each
  // output, and per-channel accepted-word counts.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];
  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  int               cnt_a;
  int               cnt_b;
  bit               model_ok = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit pop_a;
    bit pop_b;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      hold_a   = '0;
      hold_b   = '0;
      cnt_a    = 0;
      cnt_b    = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      acc   = bus.InValid && ((bus.Selector ? q_b.size() : q_a.size()) < DEPTH);
      pop_a = (q_a.size() > 0) && bus.OutA_Ready;
      pop_b = (q_b.size() > 0) && bus.OutB_Ready;
      if (pop_a) hold_a = q_a.pop_front();
      if (pop_b) hold_b = q_b.pop_front();
      if (acc) begin
        if (bus.Selector) begin
          q_b.push_back(bus.InData);
          if (cnt_b < 16'hFFFF) cnt_b++;
        end else begin
          q_a.push_back(bus.InData);
          if (cnt_a < 16'hFFFF) cnt_a++;
        end
      end
    end
  end

  // Compare process: all outputs against the model, every falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("in_ready", 32'(bus.InReady),
            32'(!rst && ((bus.Selector ? q_b.size() : q_a.size()) < DEPTH)));
      check("a_valid", 32'(bus.OutA_Valid), 32'(q_a.size() > 0));
      check("b_valid", 32'(bus.OutB_Valid), 32'(q_b.size() > 0));
      check("out_a", bus.OutA, (q_a.size() > 0) ? q_a[0] : hold_a);
      check("out_b", bus.OutB, (q_b.size() > 0) ? q_b[0] : hold_b);
      check("count_a", 32'(bus.CountA), STATS ? 32'(cnt_a) : 32'd0);
      check("count_b", 32'(bus.CountB), STATS ? 32'(cnt_b) : 32'd0);
    end
  end

  // Advance one edge; inputs are then driven 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic sel, input logic [WIDTH-1:0] data);
    bus.InValid  = 1'b1;
    bus.Selector = sel;
    bus.InData   = data;
    step();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.InValid    = 1'b0;
    bus.Selector   = 1'b0;
    bus.InData     = '0;
    bus.OutA_Ready = 1'b0;
    bus.OutB_Ready = 1'b0;

    // Reset held for two edges.
    step();
    step();
    #1;
    check("rst_in_ready", 32'(bus.InReady), 32'd0);
    check("rst_out_a", bus.OutA, 32'd0);
    check("rst_out_b", bus.OutB, 32'd0);
    check("rst_a_valid", 32'(bus.OutA_Valid), 32'd0);
    check("rst_count_a", 32'(bus.CountA), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.InReady), 32'd1);
    check("rel_b_valid", 32'(bus.OutB_Valid), 32'd0);

    // Routing: one word to each channel, consumers ready.
    bus.OutA_Ready = 1'b1;
    bus.OutB_Ready = 1'b1;
    push(1'b0, 32'd3000000);
    #1;
    check("route_a_valid", 32'(bus.OutA_Valid), 32'd1);
    check("route_a_data", bus.OutA, 32'd3000000);
    push(1'b1, 32'd4);
    bus.InValid = 1'b0;
    #1;
    check("route_a_gone", 32'(bus.OutA_Valid), 32'd0);
    check("route_b_valid", 32'(bus.OutB_Valid), 32'd1);
    check("route_b_data", bus.OutB, 32'd4);
    step();
    #1;
    check("route_b_gone", 32'(bus.OutB_Valid), 32'd0);

    // Backpressure: fill A while its consumer stalls.
    bus.OutA_Ready = 1'b0;
    push(1'b0, 32'd902);
    push(1'b0, 32'd5254513);
    bus.InValid  = 1'b1;
    bus.Selector = 1'b0;
    bus.InData   = 32'd777;
    #1;
    check("full_ready_a", 32'(bus.InReady), 32'd0);
    bus.Selector = 1'b1;
    #1;
    check("full_ready_b", 32'(bus.InReady), 32'd1);
    bus.Selector = 1'b0;
    step();                       // 777 offered to a full channel
    bus.InValid    = 1'b0;
    bus.OutA_Ready = 1'b1;
    #1;
    check("drain_first", bus.OutA, 32'd902);
    step();
    #1;
    check("drain_second", bus.OutA, 32'd5254513);
    check("unfull_ready_a", 32'(bus.InReady), 32'd1);
    step();
    #1;
    check("drain_empty", 32'(bus.OutA_Valid), 32'd0);

    // Isolation: A full and stalled while B streams.
    bus.OutA_Ready = 1'b0;
    push(1'b0, 32'd11);
    push(1'b0, 32'd22);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'(100 + i));
      #1;
      check("iso_b_data", bus.OutB, 32'(100 + i));
    end
    bus.InValid = 1'b0;
    step();
    #1;
    check("iso_a_head", bus.OutA, 32'd11);
    check("iso_a_valid", 32'(bus.OutA_Valid), 32'd1);
    bus.OutA_Ready = 1'b1;
    step();
    #1;
    check("iso_a_next", bus.OutA, 32'd22);
    bus.InValid = 1'b0;
    step();

    // Simultaneous push/pop on A across several pointer wraps.
    push(1'b0, 32'd500);
    for (int i = 1; i <= 8; i++) begin
      bus.InData = 32'(500 + i);
      #1;
      check("pp_head", bus.OutA, 32'(500 + i - 1));
      step();
    end
    #1;
    check("pp_last", bus.OutA, 32'd508);
    check("pp_valid", 32'(bus.OutA_Valid), 32'd1);
    bus.InValid = 1'b0;
    step();

    // Statistics: 5 words to A, 3 to B from a clean reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push((i >= 5), 32'(1000 + i));
    end
    bus.InValid = 1'b0;
    #1;
    check("stats_a", 32'(bus.CountA), STATS ? 32'd5 : 32'd0);
    check("stats_b", 32'(bus.CountB), STATS ? 32'd3 : 32'd0);
    push(1'b0, 32'd2000);
    rst = 1'b1;
    step();
    #1;
    check("stats_rst_a", 32'(bus.CountA), 32'd0);
    check("stats_rst_b", 32'(bus.CountB), 32'd0);
    rst         = 1'b0;
    bus.InValid = 1'b0;
    step();

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.InValid    = $urandom_range(0, 3) != 0;
      bus.Selector   = $urandom_range(0, 1) != 0;
      bus.InData     = $urandom;
      bus.OutA_Ready = $urandom_range(0, 9) < 6;
      bus.OutB_Ready = $urandom_range(0, 9) < 4;
      step();
    end
    rst         = 1'b0;
    bus.InValid = 1'b0;
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
